// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage with hold buffer, redirect and HLT handling
module instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    output logic        ifid_valid,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc,
    output logic        halted
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DISCARD = 2'd1,
        HALTED  = 2'd2
    } state_t;

    state_t      state, state_nxt;

    logic [15:0] pc, pc_nxt;
    logic [15:0] req_addr, req_addr_nxt;
    logic        pending, pending_nxt;
    // Goes high on the first clock after reset release so no request is
    // raised combinationally while reset is still asserted.
    logic        armed;

    logic        hold_valid, hold_valid_nxt;
    logic [15:0] hold_instr, hold_instr_nxt;
    logic [15:0] hold_pc, hold_pc_nxt;

    logic        ifid_valid_nxt;
    logic [15:0] ifid_instr_nxt, ifid_pc_nxt;

    logic        issue;
    logic        done;
    logic        load;
    logic [15:0] load_instr, load_pc;

    // A fresh request is only raised when nothing is outstanding or buffered.
    assign issue     = armed && (state == FETCH) && !pending && !hold_valid
                       && !stall && !redirect;
    // An outstanding request keeps its original address until it completes.
    assign imem_req  = pending || issue;
    assign imem_addr = pending ? req_addr : pc;
    assign done      = imem_req && imem_rdy;
    assign halted    = (state == HALTED);

    // Next-state, PC, hold buffer and IF/ID selection.
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        req_addr_nxt   = req_addr;
        pending_nxt    = pending;
        hold_valid_nxt = hold_valid;
        hold_instr_nxt = hold_instr;
        hold_pc_nxt    = hold_pc;
        ifid_valid_nxt = ifid_valid;
        ifid_instr_nxt = ifid_instr;
        ifid_pc_nxt    = ifid_pc;
        load           = 1'b0;
        load_instr     = imem_data;
        load_pc        = pc + 16'd1;

        if (issue && !imem_rdy) begin
            pending_nxt  = 1'b1;
            req_addr_nxt = pc;
        end
        if (pending && imem_rdy) begin
            pending_nxt = 1'b0;
        end

        if (redirect) begin
            // Redirect wins over stall; any data returning now is wrong-path.
            pc_nxt         = redirect_pc;
            ifid_valid_nxt = 1'b0;
            hold_valid_nxt = 1'b0;
            state_nxt      = (pending && !imem_rdy) ? DISCARD : FETCH;
        end else begin
            case (state)
                FETCH: begin
                    // While in FETCH the PC equals the address being fetched.
                    if (done) begin
                        pc_nxt = pc + 16'd1;
                        if (stall) begin
                            hold_valid_nxt = 1'b1;
                            hold_instr_nxt = imem_data;
                            hold_pc_nxt    = pc + 16'd1;
                        end else begin
                            load = 1'b1;
                        end
                    end else if (hold_valid && !stall) begin
                        load           = 1'b1;
                        load_instr     = hold_instr;
                        load_pc        = hold_pc;
                        hold_valid_nxt = 1'b0;
                    end

                    if (load) begin
                        ifid_valid_nxt = 1'b1;
                        ifid_instr_nxt = load_instr;
                        ifid_pc_nxt    = load_pc;
                        if (load_instr[15:12] == 4'b1111) begin
                            state_nxt = HALTED;
                        end
                    end else if (!stall) begin
                        ifid_valid_nxt = 1'b0;
                    end
                end
                DISCARD: begin
                    // Old-address data is dropped; PC already holds the target.
                    if (done) begin
                        state_nxt = FETCH;
                    end
                    if (!stall) begin
                        ifid_valid_nxt = 1'b0;
                    end
                end
                HALTED: begin
                    // HLT stays visible until decode consumes it.
                    if (!stall) begin
                        ifid_valid_nxt = 1'b0;
                    end
                end
                default: begin
                    state_nxt = FETCH;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // PC, request tracking, hold buffer and IF/ID pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed      <= 1'b0;
            pc         <= RESET_PC;
            req_addr   <= RESET_PC;
            pending    <= 1'b0;
            hold_valid <= 1'b0;
            hold_instr <= 16'h0000;
            hold_pc    <= 16'h0000;
            ifid_valid <= 1'b0;
            ifid_instr <= 16'h0000;
            ifid_pc    <= 16'h0000;
        end else begin
            armed      <= 1'b1;
            pc         <= pc_nxt;
            req_addr   <= req_addr_nxt;
            pending    <= pending_nxt;
            hold_valid <= hold_valid_nxt;
            hold_instr <= hold_instr_nxt;
            hold_pc    <= hold_pc_nxt;
            ifid_valid <= ifid_valid_nxt;
            ifid_instr <= ifid_instr_nxt;
            ifid_pc    <= ifid_pc_nxt;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy;
    logic [15:0] imem_data;
    logic        ifid_valid;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc;
    logic        halted;

    logic [15:0] mem [0:65535];

    int n_cmp;
    int n_err;

    instr_fetch #(.RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdy    (imem_rdy),
        .imem_data   (imem_data),
        .ifid_valid  (ifid_valid),
        .ifid_instr  (ifid_instr),
        .ifid_pc     (ifid_pc),
        .halted      (halted)
    );

    assign imem_data = mem[imem_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_req(input string t, input logic req, input logic [15:0] addr);
        check({t, ".req"}, 16'(imem_req), 16'(req));
        if (req) check({t, ".addr"}, imem_addr, addr);
    endtask

    task automatic chk_ifid(input string t, input logic v, input logic [15:0] instr, input logic [15:0] pc);
        check({t, ".valid"}, 16'(ifid_valid), 16'(v));
        check({t, ".instr"}, ifid_instr, instr);
        check({t, ".pc"}, ifid_pc, pc);
    endtask

    task automatic chk_reset_outputs(input string t);
        check({t, ".req"}, 16'(imem_req), 16'd0);
        check({t, ".addr"}, imem_addr, 16'h0000);
        check({t, ".valid"}, 16'(ifid_valid), 16'd0);
        check({t, ".instr"}, ifid_instr, 16'h0000);
        check({t, ".pc"}, ifid_pc, 16'h0000);
        check({t, ".halted"}, 16'(halted), 16'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 65536; i++) mem[i] = {4'h1, 12'(i)};
        mem[16'h0000] = 16'h0123;
        mem[16'h0001] = 16'h2456;
        mem[16'h0002] = 16'h3789;
        mem[16'h0005] = 16'h0ABC;
        mem[16'h0008] = 16'h5888;
        mem[16'h0009] = 16'h5999;
        mem[16'h000A] = 16'h6AAA;
        mem[16'h0020] = 16'h7020;
        mem[16'h0030] = 16'h7030;
        mem[16'h0040] = 16'h7040;
        mem[16'hFFFF] = 16'hF000;

        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000; imem_rdy = 1'b1;
        #1;
        chk_reset_outputs("rst");

        // Inputs wiggling during reset must not move any output.
        stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h1234;
        tick; tick;
        chk_reset_outputs("rst_quiet");
        stall = 1'b0; redirect = 1'b0;
        rst_n = 1'b1;
        #1 check("rel.req", 16'(imem_req), 16'd0);
        tick;

        // Zero-wait streaming from address 0.
        for (int k = 0; k < 5; k++) begin
            imem_rdy = 1'b1;
            #1 chk_req($sformatf("seq%0d", k), 1'b1, 16'(k));
            tick;
            chk_ifid($sformatf("seq%0d", k), 1'b1, mem[k], 16'(k + 1));
        end

        // Three wait states at address 5.
        for (int i = 0; i < 4; i++) begin
            imem_rdy = (i == 3);
            #1 chk_req($sformatf("wait%0d", i), 1'b1, 16'h0005);
            tick;
            if (i < 3) check($sformatf("wait%0d.valid", i), 16'(ifid_valid), 16'd0);
        end
        chk_ifid("wait_done", 1'b1, 16'h0ABC, 16'h0006);

        for (int k = 6; k < 8; k++) begin
            imem_rdy = 1'b1;
            #1 chk_req($sformatf("seq%0d", k), 1'b1, 16'(k));
            tick;
        end
        chk_ifid("seq7", 1'b1, 16'h1007, 16'h0008);

        // Data for address 8 returns while decode stalls.
        imem_rdy = 1'b0;
        #1 chk_req("st_issue", 1'b1, 16'h0008);
        tick;
        check("st_issue.valid", 16'(ifid_valid), 16'd0);
        stall = 1'b1; imem_rdy = 1'b1;
        #1 chk_req("st_ret", 1'b1, 16'h0008);
        tick;
        chk_ifid("st_ret", 1'b0, 16'h1007, 16'h0008);
        #1 check("st_hold.req", 16'(imem_req), 16'd0);
        tick;
        chk_ifid("st_hold", 1'b0, 16'h1007, 16'h0008);
        stall = 1'b0;
        #1 check("st_rel.req", 16'(imem_req), 16'd0);
        tick;
        chk_ifid("st_rel", 1'b1, 16'h5888, 16'h0009);
        #1 chk_req("st_next", 1'b1, 16'h0009);
        tick;
        chk_ifid("seq9", 1'b1, 16'h5999, 16'h000A);

        // Redirect while address 10 is outstanding.
        imem_rdy = 1'b0;
        #1 chk_req("dis_issue", 1'b1, 16'h000A);
        tick;
        redirect = 1'b1; redirect_pc = 16'h0040;
        #1 chk_req("dis_redir", 1'b1, 16'h000A);
        tick;
        check("dis_redir.valid", 16'(ifid_valid), 16'd0);
        redirect = 1'b0;
        #1 chk_req("dis_wait", 1'b1, 16'h000A);
        tick;
        imem_rdy = 1'b1;
        #1 chk_req("dis_done", 1'b1, 16'h000A);
        tick;
        chk_ifid("dis_drop", 1'b0, 16'h5999, 16'h000A);
        #1 chk_req("dis_tgt", 1'b1, 16'h0040);
        tick;
        chk_ifid("dis_tgt", 1'b1, 16'h7040, 16'h0041);

        // Stall and redirect together: redirect wins.
        stall = 1'b1; redirect = 1'b1; redirect_pc = 16'hFFFF;
        #1 check("sr.req", 16'(imem_req), 16'd0);
        tick;
        check("sr.valid", 16'(ifid_valid), 16'd0);

        // HLT at 0xFFFF: PC wraps to 0 and freezes.
        stall = 1'b0; redirect = 1'b0;
        #1 chk_req("hlt_fetch", 1'b1, 16'hFFFF);
        tick;
        chk_ifid("hlt_fetch", 1'b1, 16'hF000, 16'h0000);
        check("hlt_fetch.halted", 16'(halted), 16'd1);
        stall = 1'b1;
        #1 check("hlt_idle.req", 16'(imem_req), 16'd0);
        check("hlt_idle.addr", imem_addr, 16'h0000);
        tick;
        check("hlt_stall.valid", 16'(ifid_valid), 16'd1);
        check("hlt_stall.halted", 16'(halted), 16'd1);
        stall = 1'b0;
        #1 check("hlt_cons.req", 16'(imem_req), 16'd0);
        tick;
        check("hlt_cons.valid", 16'(ifid_valid), 16'd0);
        check("hlt_cons.halted", 16'(halted), 16'd1);
        redirect = 1'b1; redirect_pc = 16'h0020;
        #1 check("hlt_redir.req", 16'(imem_req), 16'd0);
        tick;
        check("hlt_redir.halted", 16'(halted), 16'd0);
        redirect = 1'b0;
        #1 chk_req("hlt_exit", 1'b1, 16'h0020);
        tick;
        chk_ifid("hlt_exit", 1'b1, 16'h7020, 16'h0021);

        // Redirect in the same cycle the pending data returns: no DISCARD.
        imem_rdy = 1'b0;
        #1 chk_req("rr_issue", 1'b1, 16'h0021);
        tick;
        redirect = 1'b1; redirect_pc = 16'h0030; imem_rdy = 1'b1;
        #1 chk_req("rr_ret", 1'b1, 16'h0021);
        tick;
        check("rr_ret.valid", 16'(ifid_valid), 16'd0);
        redirect = 1'b0;
        #1 chk_req("rr_tgt", 1'b1, 16'h0030);
        tick;
        chk_ifid("rr_tgt", 1'b1, 16'h7030, 16'h0031);

        // Reset in the middle of an outstanding request.
        imem_rdy = 1'b0;
        #1 chk_req("mr_issue", 1'b1, 16'h0031);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("mr_rst");
        tick;
        rst_n = 1'b1;
        #1 check("mr_rel.req", 16'(imem_req), 16'd0);
        tick;
        imem_rdy = 1'b1;
        #1 chk_req("mr_first", 1'b1, 16'h0000);
        tick;
        chk_ifid("mr_first", 1'b1, 16'h0123, 16'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, 16'h0000, word address loaded into PC at reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 stall  input  1  hazard hold from decode; holds IF/ID.
REQ-005 redirect  input  1  taken branch/JAL/JR from later stage; flushes fetch.
REQ-006 redirect_pc  input  16  new word address, sampled when redirect=1.
REQ-007 imem_req  output  1  instruction memory read request.
REQ-008 imem_addr  output  16  word address of request.
REQ-009 imem_rdy  input  1  read data valid this cycle; completes request.
REQ-010 imem_data  input  16  instruction word, valid when imem_rdy=1.
REQ-011 ifid_valid  output  1  IF/ID holds a live instruction.
REQ-012 ifid_instr  output  16  fetched instruction; [15:12] drives the opcode decoder.
REQ-013 ifid_pc  output  16  fetch address + 1.
REQ-014 halted  output  1  fetch stopped on HLT (opcode 4'b1111).

Function
REQ-015 States: FETCH, DISCARD, HALTED; reset state FETCH.
REQ-016 PC is word-addressed, 16 bits; increment wraps 16'hFFFF -> 16'h0000.
REQ-017 Request handshake: once imem_req=1 with rdy=0, imem_req and imem_addr hold stable until the imem_rdy=1 cycle, regardless of stall/redirect.
REQ-018 New request (imem_req=1, imem_addr=PC) issued in FETCH when no request pending, hold buffer empty, stall=0, redirect=0.
REQ-019 Zero-wait latency: request with imem_rdy=1 in cycle N -> ifid_instr/ifid_valid updated at end of N; PC advances by 1; sustained throughput 1 instr/cycle.
REQ-020 Data returning while stall=1 goes to a 1-entry hold buffer (instr, pc+1); IF/ID unchanged.
REQ-021 First cycle with stall=0 and hold buffer full: IF/ID loads hold buffer, buffer cleared, imem_req=0 that cycle.
REQ-022 stall=1: IF/ID registers and ifid_valid held.
REQ-023 stall=0 with no instruction loaded: ifid_valid <= 0 (bubble).
REQ-024 redirect=1: PC <= redirect_pc, ifid_valid <= 0, hold buffer cleared; redirect overrides stall.
REQ-025 redirect with request pending and rdy=0: state DISCARD; request completes at old address, data dropped, then FETCH at redirect_pc.
REQ-026 redirect in same cycle as imem_rdy=1: returned data dropped, no DISCARD.
REQ-027 Loading an instruction with opcode 4'b1111 into IF/ID: state HALTED, halted=1, imem_req=0, PC frozen.
REQ-028 HALTED exits only on redirect (wrong-path HLT cancelled) -> FETCH at redirect_pc, halted=0; or reset.
REQ-029 In HALTED, HLT remains in IF/ID until consumed (stall=0), then ifid_valid=0.

Reset
REQ-030 rst_n=0 asynchronously forces: PC=RESET_PC, state FETCH, imem_req=0, imem_addr=RESET_PC, ifid_valid=0, ifid_instr=16'h0000, ifid_pc=16'h0000, hold empty, halted=0.
REQ-031 Reset mid-request abandons pending request; first request issued cycle after rst_n rises.
REQ-032 No output toggles while rst_n=0 regardless of other inputs.

Verification
REQ-033 Reset, imem_rdy tied 1, mem[0..2]=16'h0123,16'h2456,16'h3789 -> imem_addr 0,1,2 consecutive cycles; ifid_instr same order, ifid_pc 1,2,3, ifid_valid=1 each.
REQ-034 imem_rdy low 3 cycles on addr 5 -> imem_req/addr=5 stable 4 cycles; ifid_valid=0 during wait; 16'h0ABC loaded with ifid_pc=6.
REQ-035 stall=1 at addr 8, data returns during stall -> IF/ID holds prior instr; on stall=0 IF/ID=mem[8], ifid_pc=9, imem_req=0 that cycle, request addr 9 next.
REQ-036 redirect=1, redirect_pc=16'h0040, while addr 10 pending (rdy=0) -> DISCARD; mem[10] never in IF/ID; next request addr 16'h0040.
REQ-037 Fetch 16'hF000 at addr 16'hFFFF -> halted=1, imem_req=0, PC=16'h0000 frozen; redirect to 16'h0020 -> halted=0, request addr 16'h0020.
REQ-038 stall=1 and redirect=1 same cycle -> ifid_valid=0 next cycle, PC=redirect_pc.
